layer_scan_ctrl: RTL

//  Layer multiplexer for the 4x4x4 LED cube; consumes the stretched blanking pulse and feeds its trigger.

---
 rtl/layer_scan_ctrl_pkg.sv | 27 ++
 rtl/layer_scan_ctrl_if.sv | 25 ++
 rtl/layer_scan_ctrl_dwell_timer.sv | 38 +++
 rtl/layer_scan_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/layer_scan_ctrl_pkg.sv
// layer_scan_ctrl_pkg: shared types and helpers for the LED cube layer scanner.
// Holds cube geometry, FSM state encoding and layer slice helpers.
package layer_scan_ctrl_pkg;

    localparam int LAYERS = 4;
    localparam int COLS   = 16;
    localparam int FRAME_W = LAYERS * COLS;

    typedef enum logic [1:0] {
        ST_REQ       = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_WAIT_FALL = 2'd2,
        ST_DWELL     = 2'd3
    } scan_state_e;

    function automatic logic [LAYERS-1:0] layer_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    function automatic logic [COLS-1:0] layer_cols(
        input logic [FRAME_W-1:0] frame,
        input logic [1:0]         idx
    );
        return frame[{idx, 4'd0} +: COLS];
    endfunction

endpackage

// File: rtl/layer_scan_ctrl_if.sv
// layer_scan_ctrl_if: frame, blanking and LED drive signals of the scanner.
// master drives frames and blanking; slave is the scanner itself.
interface layer_scan_ctrl_if;
    import layer_scan_ctrl_pkg::*;

    logic               blank_in;
    logic [FRAME_W-1:0] frame_data;
    logic               frame_valid;
    logic               frame_ack;
    logic               switch_req;
    logic [LAYERS-1:0]  layer_en;
    logic [COLS-1:0]    col;
    logic               blank_err;

    modport master (
        output blank_in, frame_data, frame_valid,
        input  frame_ack, switch_req, layer_en, col, blank_err
    );

    modport slave (
        input  blank_in, frame_data, frame_valid,
        output frame_ack, switch_req, layer_en, col, blank_err
    );

endinterface

// File: rtl/layer_scan_ctrl_dwell_timer.sv
// layer_scan_ctrl_dwell_timer: loadable down counter with zero flag.
// Shared between the layer dwell period and the blank rise timeout.
module layer_scan_ctrl_dwell_timer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // load wins over decrement; counter parks at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/layer_scan_ctrl.sv
// layer_scan_ctrl: lights one cube layer per dwell, blanks between layers
// via the stretcher handshake, and swaps frames only at the layer 3->0 wrap.
module layer_scan_ctrl
    import layer_scan_ctrl_pkg::*;
#(
    parameter int DWELL_CYCLES  = 2048,
    parameter int DWELL_W       = 12,
    parameter int BLANK_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    layer_scan_ctrl_if.slave bus
);

    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [DWELL_W-1:0] TMO_LOAD   = DWELL_W'(BLANK_TIMEOUT - 1);

    scan_state_e        state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [FRAME_W-1:0] disp_q, disp_d;
    logic [LAYERS-1:0]  layer_en_q, layer_en_d;
    logic [COLS-1:0]    col_q, col_d;
    logic               sw_q, sw_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               blank_prev_q;

    logic               tmr_load;
    logic [DWELL_W-1:0] tmr_val;
    logic               tmr_dec;
    logic               tmr_zero;
    logic               adv;

    layer_scan_ctrl_dwell_timer #(
        .W (DWELL_W)
    ) u_timer (
        .clk        (clk),
        .rst        (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // scan FSM: blank handshake, layer advance, frame capture, output drive
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        disp_d     = disp_q;
        layer_en_d = layer_en_q;
        col_d      = col_q;
        sw_d       = 1'b0;
        ack_d      = 1'b0;
        err_d      = err_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_dec    = 1'b0;
        adv        = 1'b0;

        unique case (state_q)
            ST_REQ: begin
                sw_d       = 1'b1;
                layer_en_d = '0;
                col_d      = '0;
                tmr_load   = 1'b1;
                tmr_val    = TMO_LOAD;
                state_d    = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (bus.blank_in) begin
                    state_d = ST_WAIT_FALL;
                end else if (tmr_zero) begin
                    err_d = 1'b1;
                    adv   = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_WAIT_FALL: begin
                if (blank_prev_q && !bus.blank_in) begin
                    adv = 1'b1;
                end
            end
            ST_DWELL: begin
                if (bus.blank_in) begin
                    err_d = 1'b1;
                end
                if (tmr_zero) begin
                    layer_en_d = '0;
                    col_d      = '0;
                    state_d    = ST_REQ;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        // new frame is only accepted when stepping onto layer 0
        if (adv) begin
            idx_d = (idx_q == 2'd3) ? 2'd0 : idx_q + 2'd1;
            if ((idx_d == 2'd0) && bus.frame_valid) begin
                disp_d = bus.frame_data;
                ack_d  = 1'b1;
            end
            layer_en_d = layer_onehot(idx_d);
            col_d      = layer_cols(disp_d, idx_d);
            tmr_load   = 1'b1;
            tmr_val    = DWELL_LOAD;
            state_d    = ST_DWELL;
        end
    end

    // state, buffer and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_REQ;
            idx_q        <= 2'd3;
            disp_q       <= '0;
            layer_en_q   <= '0;
            col_q        <= '0;
            sw_q         <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            blank_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            layer_en_q   <= layer_en_d;
            col_q        <= col_d;
            sw_q         <= sw_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            blank_prev_q <= bus.blank_in;
        end
    end

    assign bus.layer_en   = layer_en_q;
    assign bus.col        = col_q;
    assign bus.switch_req = sw_q;
    assign bus.frame_ack  = ack_q;
    assign bus.blank_err  = err_q;

endmodule
